// File: rtl/spi_cmd_rx_pkg.sv
// Shared constants and FSM encoding for the SPI command receiver.
// Word layout: opcode in the top OPC_BITS, payload in the low bits.
package spi_cmd_rx_pkg;

  localparam int WORD_BITS = 16;
  localparam int OPC_BITS  = 4;
  localparam int CONF_BITS = WORD_BITS - OPC_BITS;
  localparam int DIV_BITS  = 8;

  // Counter must hold WORD_BITS+1 so an overlong frame stays distinguishable.
  localparam int                 CNT_BITS  = $clog2(WORD_BITS + 2);
  localparam logic [CNT_BITS-1:0] CNT_WORD = CNT_BITS'(WORD_BITS);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(WORD_BITS + 1);

  localparam logic [OPC_BITS-1:0] OPC_SET_CONFREG = OPC_BITS'(1);
  localparam logic [OPC_BITS-1:0] OPC_SET_DIVISOR = OPC_BITS'(2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_DECODE
  } state_t;

endpackage

// File: rtl/spi_cmd_rx_if.sv
// SPI pin bundle between the host (master) and the FPGA receiver (slave).
interface spi_cmd_rx_if;

  logic spck;
  logic mosi;
  logic ncs;
  logic miso;

  modport master (output spck, output mosi, output ncs, input miso);
  modport slave  (input spck, input mosi, input ncs, output miso);

endinterface

// File: rtl/spi_cmd_rx_sync_edge.sv
// Two-flop synchronizer plus history flop for one asynchronous pin.
// Provides the synchronized level and single-cycle rise/fall pulses.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic hist;

  // NOTE: all three flops reset to the pin's idle level so reset release never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      hist <= RST_VAL;
    end else begin
      meta <= pin;
      sync <= meta;
      hist <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~hist;
  assign fall  = ~sync & hist;

endmodule

// File: rtl/spi_cmd_rx.sv
// SPI slave front end: oversamples spck/mosi/ncs, shifts a status word out on
// miso, and decodes each completed frame into conf_reg / divisor updates.
module spi_cmd_rx
  import spi_cmd_rx_pkg::*;
(
  input  logic                 ck_1356meg,
  input  logic                 nreset,
  spi_cmd_rx_if.slave          spi,
  input  logic [WORD_BITS-1:0] status_in,
  output logic [CONF_BITS-1:0] conf_reg,
  output logic                 conf_stb,
  output logic [DIV_BITS-1:0]  divisor,
  output logic                 div_stb,
  output logic                 frame_err,
  output logic                 cmd_err
);

  logic spck_lvl, spck_rise, spck_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic ncs_lvl,  ncs_rise,  ncs_fall;

  sync_edge #(.RST_VAL(1'b1)) u_sync_spck (
    .clk(ck_1356meg), .rst_n(nreset), .pin(spi.spck),
    .level(spck_lvl), .rise(spck_rise), .fall(spck_fall)
  );

  sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(ck_1356meg), .rst_n(nreset), .pin(spi.mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  sync_edge #(.RST_VAL(1'b1)) u_sync_ncs (
    .clk(ck_1356meg), .rst_n(nreset), .pin(spi.ncs),
    .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
  );

  // Only some synchronizer outputs drive logic; fold the rest away explicitly.
  logic unused_ok;
  assign unused_ok = &{1'b0, spck_lvl, mosi_rise, mosi_fall, ncs_fall};

  state_t               state;
  logic [CNT_BITS-1:0]  count;
  logic [WORD_BITS-1:0] rx_shift;
  logic [WORD_BITS-1:0] tx_shift;
  logic                 miso_q;

  assign spi.miso = miso_q;

  // NOTE: state is updated with non-blocking assignments only; strobes default
  // low every cycle so each one is a single-cycle pulse.
  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      state     <= ST_IDLE;
      count     <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      miso_q    <= 1'b0;
      conf_reg  <= '0;
      divisor   <= '0;
      conf_stb  <= 1'b0;
      div_stb   <= 1'b0;
      frame_err <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      conf_stb  <= 1'b0;
      div_stb   <= 1'b0;
      frame_err <= 1'b0;
      cmd_err   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!ncs_lvl) begin
            state    <= ST_RECV;
            count    <= '0;
            tx_shift <= status_in;
            miso_q   <= status_in[WORD_BITS-1];
          end
        end

        ST_RECV: begin
          // Frame end wins over any spck edge landing in the same cycle.
          if (ncs_rise) begin
            state <= ST_DECODE;
          end else if (spck_rise) begin
            rx_shift <= {rx_shift[WORD_BITS-2:0], mosi_lvl};
            if (count != CNT_MAX) count <= count + CNT_BITS'(1);
          end else if (spck_fall) begin
            tx_shift <= {tx_shift[WORD_BITS-2:0], 1'b0};
            miso_q   <= tx_shift[WORD_BITS-2];
          end
        end

        ST_DECODE: begin
          state <= ST_IDLE;
          if (count != CNT_WORD) begin
            frame_err <= 1'b1;
          end else begin
            case (rx_shift[WORD_BITS-1 -: OPC_BITS])
              OPC_SET_CONFREG: begin
                conf_reg <= rx_shift[CONF_BITS-1:0];
                conf_stb <= 1'b1;
              end
              OPC_SET_DIVISOR: begin
                divisor <= rx_shift[DIV_BITS-1:0];
                div_stb <= 1'b1;
              end
              default: cmd_err <= 1'b1;
            endcase
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Self-checking bench for spi_cmd_rx: drives SPI frames from a host model and
// compares every strobe event and register value against a frame-level model.
module tb_spi_cmd_rx;
  import spi_cmd_rx_pkg::*;

  localparam int HALF   = 6;   // spck phase length in clock cycles
  localparam int K_CONF = 1;
  localparam int K_DIV  = 2;
  localparam int K_FERR = 4;
  localparam int K_CERR = 8;

  logic                 clk = 1'b0;
  logic                 nreset;
  logic [WORD_BITS-1:0] status_in;
  logic [CONF_BITS-1:0] conf_reg;
  logic                 conf_stb;
  logic [DIV_BITS-1:0]  divisor;
  logic                 div_stb;
  logic                 frame_err;
  logic                 cmd_err;

  spi_cmd_rx_if spi ();

  spi_cmd_rx dut (
    .ck_1356meg (clk),
    .nreset     (nreset),
    .spi        (spi),
    .status_in  (status_in),
    .conf_reg   (conf_reg),
    .conf_stb   (conf_stb),
    .divisor    (divisor),
    .div_stb    (div_stb),
    .frame_err  (frame_err),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int        kind;
    int        cyc;
    logic [11:0] conf;
    logic [7:0]  div;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];

  // Frame-level reference state
  logic [11:0] m_conf;
  logic [7:0]  m_div;
  logic [15:0] m_rx;
  int          m_nb;

  // Record every cycle in which any strobe is high, with the register values.
  always @(negedge clk) begin
    if (nreset === 1'b1 && (conf_stb | div_stb | frame_err | cmd_err)) begin
      ev_t e;
      e.kind = int'({cmd_err, frame_err, div_stb, conf_stb});
      e.cyc  = cyc;
      e.conf = conf_reg;
      e.div  = divisor;
      obs_q.push_back(e);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low(input int gap);
    spi.spck = 1'b0;
    wait_cyc(gap);
    spi.ncs = 1'b0;
    m_nb = 0;
    m_rx = '0;
    wait_cyc(HALF);
  endtask

  // spck is low on entry; miso is sampled just before the rising edge.
  task automatic send_bit(input logic b, input bit is_last, input bit chk,
                          input logic exp_miso, input int idx);
    spi.mosi = b;
    wait_cyc(HALF);
    if (chk) check($sformatf("miso_bit%0d", idx), {31'd0, spi.miso}, {31'd0, exp_miso});
    spi.spck = 1'b1;
    m_rx = {m_rx[14:0], b};
    m_nb++;
    wait_cyc(HALF);
    if (!is_last) spi.spck = 1'b0;
  endtask

  task automatic cs_high(input bit drop_spck);
    ev_t e;
    spi.ncs = 1'b1;
    if (drop_spck) spi.spck = 1'b0;
    e.cyc = cyc + 4;
    if (m_nb != 16) begin
      e.kind = K_FERR;
    end else if (m_rx[15:12] == 4'd1) begin
      m_conf = m_rx[11:0];
      e.kind = K_CONF;
    end else if (m_rx[15:12] == 4'd2) begin
      m_div  = m_rx[7:0];
      e.kind = K_DIV;
    end else begin
      e.kind = K_CERR;
    end
    e.conf = m_conf;
    e.div  = m_div;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [31:0] data, input int n, input bit chk_miso,
                            input int gap, input bit drop_end);
    logic [15:0] st;
    st = status_in;
    cs_low(gap);
    for (int i = 0; i < n; i++) begin
      send_bit(data[n-1-i], i == n - 1, chk_miso && i < 16,
               (i < 16) ? st[15-i] : 1'b0, i);
    end
    cs_high(drop_end);
  endtask

  task automatic drain(input string tag);
    int n;
    wait_cyc(10);
    check({tag, "_events"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_kind%0d", tag, i), obs_q[i].kind, exp_q[i].kind);
      check($sformatf("%s_lat%0d", tag, i), obs_q[i].cyc, exp_q[i].cyc);
      check($sformatf("%s_conf%0d", tag, i), {20'd0, obs_q[i].conf}, {20'd0, exp_q[i].conf});
      check($sformatf("%s_div%0d", tag, i), {24'd0, obs_q[i].div}, {24'd0, exp_q[i].div});
    end
    obs_q.delete();
    exp_q.delete();
    check({tag, "_conf_reg"}, {20'd0, conf_reg}, {20'd0, m_conf});
    check({tag, "_divisor"}, {24'd0, divisor}, {24'd0, m_div});
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] w;
    int          len;

    nreset    = 1'b0;
    spi.spck  = 1'b1;
    spi.ncs   = 1'b1;
    spi.mosi  = 1'b0;
    status_in = '0;
    m_conf    = '0;
    m_div     = '0;
    m_rx      = '0;
    m_nb      = 0;

    wait_cyc(3);
    check("rst_conf_reg", {20'd0, conf_reg}, 32'd0);
    check("rst_divisor", {24'd0, divisor}, 32'd0);
    check("rst_miso", {31'd0, spi.miso}, 32'd0);
    check("rst_strobes", {28'd0, cmd_err, frame_err, div_stb, conf_stb}, 32'd0);
    nreset = 1'b1;
    wait_cyc(6);

    send_frame(32'h1ABC, 16, 1'b0, HALF, 1'b0);
    drain("conf_1abc");

    send_frame(32'h2F5A, 16, 1'b0, HALF, 1'b0);
    drain("div_2f5a");

    r = $urandom;
    send_frame(r, 8, 1'b0, HALF, 1'b0);
    drain("short8");

    r = $urandom;
    send_frame(r, 17, 1'b0, HALF, 1'b0);
    drain("long17");

    send_frame(32'h0, 0, 1'b0, HALF, 1'b0);
    drain("zero_len");

    // Unknown opcode, then a back-to-back frame after a 4-cycle ncs gap.
    send_frame(32'h7123, 16, 1'b0, HALF, 1'b1);
    send_frame(32'h1001, 16, 1'b0, 4, 1'b0);
    drain("b2b");

    status_in = 16'hC3A5;
    r = $urandom;
    send_frame(r, 16, 1'b1, HALF, 1'b0);
    drain("miso_c3a5");

    for (int f = 0; f < 20; f++) begin
      r = $urandom;
      case ($urandom_range(0, 3))
        0:       w = {16'd0, 4'd1, r[11:0]};
        1:       w = {16'd0, 4'd2, r[11:0]};
        default: w = r;
      endcase
      len = ($urandom_range(0, 9) < 7) ? 16 : int'($urandom_range(0, 20));
      status_in = r[31:16];
      send_frame(w, len, 1'b1, HALF, 1'b0);
      drain($sformatf("rand%0d", f));
    end

    // Reset in the middle of a frame, released while ncs is still low.
    w = 32'h1FFF;
    cs_low(HALF);
    for (int i = 0; i < 6; i++) send_bit(w[15-i], 1'b0, 1'b0, 1'b0, i);
    nreset = 1'b0;
    #1;
    check("midrst_conf_reg", {20'd0, conf_reg}, 32'd0);
    check("midrst_divisor", {24'd0, divisor}, 32'd0);
    check("midrst_miso", {31'd0, spi.miso}, 32'd0);
    m_conf = '0;
    m_div  = '0;
    m_nb   = 0;
    m_rx   = '0;
    obs_q.delete();
    exp_q.delete();
    wait_cyc(3);
    nreset = 1'b1;
    wait_cyc(8);
    for (int i = 6; i < 16; i++) send_bit(w[15-i], i == 15, 1'b0, 1'b0, i);
    cs_high(1'b0);
    drain("reset_mid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
